// File: rtl/mp_add_seq_if.sv
// mp_add_seq_if: operand and result streams of the multi-precision add sequencer.
//   in_*  : operand word stream (valid/ready), least-significant word first.
//   out_* : result word stream (valid/ready), one result per operand word.
// Modports:
//   master : the producer of operands and consumer of results.
//   slave  : the sequencer itself.
interface mp_add_seq_if #(
    parameter int unsigned W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_first;
    logic         in_last;
    logic         in_cin;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_last;
    logic         out_cout;

    modport master (
        output in_valid, in_a, in_b, in_first, in_last, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_last, out_cout
    );

    modport slave (
        input  in_valid, in_a, in_b, in_first, in_last, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_last, out_cout
    );
endinterface

// File: rtl/mp_add_seq.sv
// mp_add_seq: feeds an external registered W-bit adder one word pair per cycle, chains
// carries between the words of an operation and collects the adder results into a
// small result FIFO.
// Ports:
//   TClk, TRst : clock (rising edge) and synchronous active-high reset.
//   bus        : operand stream in, result stream out (mp_add_seq_if.slave).
//   ra, rb, cin: operands to the adder, zero when no word is issued.
//   Sum, Cout  : registered adder result, valid the cycle after an issue.
//   err        : sticky protocol error (first/last framing violated).
module mp_add_seq #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic         TClk,
    input  logic         TRst,
    mp_add_seq_if.slave  bus,
    output logic [W-1:0] ra,
    output logic [W-1:0] rb,
    output logic         cin,
    input  logic [W-1:0] Sum,
    input  logic         Cout,
    output logic         err
);
    typedef enum logic [1:0] {StIdle, StBusy, StErr} state_e;

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

    state_e          state_q, state_d;
    logic            err_q, err_set;
    logic            carry_q, issue_d1_q, last_d1_q;
    logic [W+1:0]    mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [CntW-1:0] credit_used;
    logic            in_ready, issue, push, pop, out_valid;
    logic [W+1:0]    head;

    // Credit: a word in the adder register already owns a FIFO slot, so the FIFO
    // can never overflow and in_ready never looks at out_ready.
    assign credit_used = count_q + CntW'(issue_d1_q);
    assign in_ready    = !TRst && (state_q != StErr) && (credit_used < DepthC);
    assign issue       = bus.in_valid && in_ready;

    assign ra = issue ? bus.in_a : '0;
    assign rb = issue ? bus.in_b : '0;

    // When the previous word was issued last cycle its carry is still in the adder
    // register; after a gap the adder holds zeros, so use the saved carry.
    always_comb begin
        cin = 1'b0;
        if (issue) begin
            if (bus.in_first) begin
                cin = bus.in_cin;
            end else if (issue_d1_q) begin
                cin = Cout;
            end else begin
                cin = carry_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        case (state_q)
            StIdle: begin
                if (issue) begin
                    if (!bus.in_first) begin
                        state_d = StErr;
                        err_set = 1'b1;
                    end else if (!bus.in_last) begin
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (issue) begin
                    if (bus.in_first) begin
                        state_d = StErr;
                        err_set = 1'b1;
                    end else if (bus.in_last) begin
                        state_d = StIdle;
                    end
                end
            end
            StErr:   state_d = StErr;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge TClk) begin
        if (TRst) begin
            state_q    <= StIdle;
            err_q      <= 1'b0;
            carry_q    <= 1'b0;
            issue_d1_q <= 1'b0;
            last_d1_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (issue_d1_q) begin
                carry_q <= Cout;
            end
            issue_d1_q <= issue;
            last_d1_q  <= issue && bus.in_last;
        end
    end

    assign push      = issue_d1_q;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && bus.out_ready;

    always_ff @(posedge TClk) begin
        if (TRst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry layout: {sum, last, cout}; cout is kept only for the MSW.
    always_ff @(posedge TClk) begin
        if (push && !TRst) begin
            mem_q[wr_ptr_q] <= {Sum, last_d1_q, last_d1_q & Cout};
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_sum   = out_valid ? head[W+1:2] : '0;
    assign bus.out_last  = out_valid & head[1];
    assign bus.out_cout  = out_valid & head[0];
    assign err           = err_q;
endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq: bench for mp_add_seq with a registered adder model attached.
module tb_mp_add_seq;
    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [W-1:0] sum;
        logic         last;
        logic         cout;
    } res_t;

    typedef struct {
        int           n;
        logic [127:0] a;
        logic [127:0] b;
        logic         c;
        int           gap;
        logic [127:0] es;
        logic         ec;
    } vec_t;

    logic         TClk = 1'b0;
    logic         TRst;
    logic [W-1:0] ra, rb, Sum;
    logic         cin, Cout, err;

    mp_add_seq_if #(.W(W)) bus ();

    mp_add_seq #(.W(W), .DEPTH(DEPTH)) dut (
        .TClk (TClk),
        .TRst (TRst),
        .bus  (bus),
        .ra   (ra),
        .rb   (rb),
        .cin  (cin),
        .Sum  (Sum),
        .Cout (Cout),
        .err  (err)
    );

    always #5 TClk = ~TClk;

    // The existing registered 32-bit adder.
    always @(posedge TClk) begin
        {Cout, Sum} <= {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, cin};
    end

    int   n_checks = 0;
    int   n_fail   = 0;
    int   outstanding = 0;
    bit   rand_en = 1'b0;
    res_t exp_q[$];

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Result monitor: every popped word must match the head of the expected queue.
    always @(negedge TClk) begin
        res_t e;
        if (TRst) begin
            outstanding = 0;
        end else begin
            chk("fifo_bound", (outstanding <= int'(DEPTH)), 1);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got sum %h, expected no result",
                             bus.out_sum);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_sum", bus.out_sum, e.sum);
                    chk("out_last", bus.out_last, e.last);
                    chk("out_cout", bus.out_cout, e.cout);
                end
            end
            outstanding += int'(bus.in_valid && bus.in_ready)
                         - int'(bus.out_valid && bus.out_ready);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge TClk);
            #1;
            if (rand_en) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic try_word(input logic [W-1:0] a, input logic [W-1:0] b, input logic first,
                            input logic last, input logic c, input int limit, output bit acc);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_first = first;
        bus.in_last  = last;
        bus.in_cin   = c;
        bus.in_valid = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < limit && !acc; k++) begin
            @(negedge TClk);
            acc = bus.in_ready;
            tick(1);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b, input logic first,
                             input logic last, input logic c);
        bit acc;
        try_word(a, b, first, last, c, 200, acc);
        chk("accept_timeout", acc, 1);
    endtask

    task automatic send_op(input logic [127:0] a, input logic [127:0] b, input int n,
                           input logic c, input int gap);
        for (int i = 0; i < n; i++) begin
            send_word(a[W*i +: W], b[W*i +: W], (i == 0), (i == n - 1), c);
            if (i < n - 1) tick(gap);
        end
    endtask

    task automatic push_exp(input logic [127:0] es, input int n, input logic ec);
        res_t r;
        for (int i = 0; i < n; i++) begin
            r.sum  = es[W*i +: W];
            r.last = (i == n - 1);
            r.cout = (i == n - 1) ? ec : 1'b0;
            exp_q.push_back(r);
        end
    endtask

    function automatic vec_t mk(input int n, input logic [127:0] a, input logic [127:0] b,
                                input logic c, input int gap, input logic [127:0] es,
                                input logic ec);
        vec_t v;
        v.n = n; v.a = a; v.b = b; v.c = c; v.gap = gap; v.es = es; v.ec = ec;
        return v;
    endfunction

    task automatic drain(input string name);
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick(1);
        chk(name, exp_q.size(), 0);
    endtask

    vec_t         vecs[6];
    logic [127:0] ra_w, rb_w, mask;
    logic [128:0] full;
    logic [W:0]   wsum;
    logic         rc;
    int           n_words, n_acc;
    bit           acc;

    initial begin
        vecs[0] = mk(2, 128'h00000000_FFFFFFFF, 128'h00000000_00000001, 1'b0, 0,
                     128'h00000001_00000000, 1'b0);
        vecs[1] = mk(1, 128'h80000000, 128'h80000000, 1'b1, 0, 128'h00000001, 1'b1);
        vecs[2] = mk(2, 128'h00000000_FFFFFFFF, 128'h00000000_00000001, 1'b0, 3,
                     128'h00000001_00000000, 1'b0);
        vecs[3] = mk(2, 128'hFFFFFFFF_FFFFFFFF, 128'h00000000_00000001, 1'b0, 3,
                     128'h00000000_00000000, 1'b1);
        vecs[4] = mk(4, {128{1'b1}}, 128'h1, 1'b0, 0, 128'h0, 1'b1);
        vecs[5] = mk(3, 128'h00000000_12345678_FFFFFFFF, 128'h00000000_11111111_00000001,
                     1'b1, 1, 128'h00000000_2345678A_00000001, 1'b0);

        TRst = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
        bus.in_first = 1'b0; bus.in_last = 1'b0; bus.in_cin = 1'b0;
        bus.out_ready = 1'b1;
        tick(3);
        chk("in_ready_in_reset", bus.in_ready, 0);
        TRst = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_sum", bus.out_sum, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_out_cout", bus.out_cout, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_ra", ra, 0);
        chk("rst_cin", cin, 0);
        tick(1);

        // 64-bit add on consecutive cycles, latency checked cycle by cycle.
        push_exp(vecs[0].es, 2, 1'b0);
        bus.in_a = 32'hFFFFFFFF; bus.in_b = 32'h1; bus.in_first = 1'b1; bus.in_last = 1'b0;
        bus.in_cin = 1'b0; bus.in_valid = 1'b1;
        #1;
        chk("lat_ra", ra, 32'hFFFFFFFF);
        chk("lat_cin0", cin, 0);
        tick(1);
        bus.in_a = 32'h0; bus.in_b = 32'h0; bus.in_first = 1'b0; bus.in_last = 1'b1;
        #1;
        chk("lat_cin_chain", cin, 1);
        chk("lat_t1_valid", bus.out_valid, 0);
        tick(1);
        bus.in_valid = 1'b0;
        #1;
        chk("lat_ra_idle", ra, 0);
        chk("lat_t2_valid", bus.out_valid, 1);
        chk("lat_t2_sum", bus.out_sum, 32'h0);
        chk("lat_t2_last", bus.out_last, 0);
        tick(1);
        chk("lat_t3_valid", bus.out_valid, 1);
        chk("lat_t3_sum", bus.out_sum, 32'h1);
        chk("lat_t3_last", bus.out_last, 1);
        chk("lat_t3_cout", bus.out_cout, 0);
        tick(1);
        chk("lat_t4_valid", bus.out_valid, 0);

        // Table of fixed operations, including input gaps between words.
        foreach (vecs[i]) begin
            push_exp(vecs[i].es, vecs[i].n, vecs[i].ec);
            send_op(vecs[i].a, vecs[i].b, vecs[i].n, vecs[i].c, vecs[i].gap);
        end
        drain("table_drain");

        // Backpressure: exactly DEPTH single-word ops fit while out_ready is low.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wsum = {1'b0, 32'hFFFFFFF0 + 32'(i)} + 33'h20 + 33'(i % 2);
            push_exp({96'h0, wsum[W-1:0]}, 1, wsum[W]);
        end
        n_acc = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            try_word(32'hFFFFFFF0 + 32'(i), 32'h20, 1'b1, 1'b1, 1'(i % 2), 8, acc);
            n_acc += int'(acc);
        end
        try_word(32'hFFFFFFF4, 32'h20, 1'b1, 1'b1, 1'b0, 8, acc);
        chk("bp_extra_blocked", acc, 0);
        chk("bp_accepted", n_acc, DEPTH);
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_held_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        send_word(32'hFFFFFFF4, 32'h20, 1'b1, 1'b1, 1'b0);
        send_word(32'hFFFFFFF5, 32'h20, 1'b1, 1'b1, 1'b1);
        drain("bp_drain");

        // Protocol error: second word claims to be first while BUSY.
        push_exp(128'h3, 1, 1'b0);
        exp_q[exp_q.size() - 1].last = 1'b0;
        push_exp(128'h1F, 1, 1'b0);
        send_word(32'd1, 32'd2, 1'b1, 1'b0, 1'b0);
        send_word(32'd10, 32'd20, 1'b1, 1'b1, 1'b1);
        chk("perr_err", err, 1);
        chk("perr_in_ready", bus.in_ready, 0);
        drain("perr_drain");
        try_word(32'd5, 32'd5, 1'b1, 1'b1, 1'b0, 5, acc);
        chk("perr_blocked", acc, 0);
        chk("perr_sticky", err, 1);
        TRst = 1'b1;
        tick(1);
        TRst = 1'b0;
        #1;
        chk("perr_rst_err", err, 0);
        chk("perr_rst_valid", bus.out_valid, 0);
        chk("perr_rst_ready", bus.in_ready, 1);
        push_exp(128'h0000000A, 1, 1'b0);
        send_op(128'd5, 128'd4, 1, 1'b1, 0);
        drain("perr_after");

        // Reset one cycle after word 0 of a 128-bit op: its result must vanish.
        send_word(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1);
        TRst = 1'b1;
        tick(1);
        TRst = 1'b0;
        #1;
        chk("mrst_valid", bus.out_valid, 0);
        tick(4);
        chk("mrst_quiet", bus.out_valid, 0);
        push_exp(vecs[2].es, 2, vecs[2].ec);
        send_op(vecs[2].a, vecs[2].b, 2, 1'b0, 2);
        drain("mrst_fresh");

        // Random multi-word ops against whole-number arithmetic.
        rand_en = 1'b1;
        for (int op = 0; op < 150; op++) begin
            n_words = $urandom_range(1, 4);
            for (int i = 0; i < 4; i++) begin
                ra_w[W*i +: W] = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
                rb_w[W*i +: W] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1))
                                                             : $urandom;
            end
            rc   = 1'($urandom_range(0, 1));
            mask = (128'd1 << (32 * n_words)) - 128'd1;
            full = {1'b0, ra_w & mask} + {1'b0, rb_w & mask} + 129'(rc);
            push_exp(full[127:0], n_words, full[32 * n_words]);
            send_op(ra_w, rb_w, n_words, rc, $urandom_range(0, 2));
            tick($urandom_range(0, 2));
        end
        rand_en = 1'b0;
        bus.out_ready = 1'b1;
        drain("rand_drain");
        chk("rand_err", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
